// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   InstAddrBus / InstBus : address and instruction widths
//   ZeroWord / NopInst    : all-zero word, also the bubble instruction
//   RstEnable             : active level of the synchronous reset
//   IfFifoDepth           : default fetch buffer depth / request credit
//   fetch_entry_t         : one {pc, inst} pair as carried through the stage
package if_fetch_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic [31:0] NopInst     = ZeroWord;
  localparam int          IfFifoDepth = 2;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  localparam fetch_entry_t NopEntry = '{pc: ZeroWord, inst: NopInst};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} pairs for the fetch stage.
//   clk, rst : clock and synchronous active-high reset
//   clear    : drop every entry (wins over push)
//   push/din : write one entry
//   pop      : retire the head entry (ignored when empty)
//   head     : oldest entry (undefined when count is zero)
//   count    : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = IfFifoDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           din,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !clear && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone defines validity,
  // which keeps the array as plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to
// instruction memory, buffers returned words and feeds decode through a
// registered IF/ID boundary.
//   clk, rst         : clock, synchronous active-high reset
//   stall_i          : decode cannot accept, hold id_pc_o/id_inst_o
//   flush_i          : redirect to flush_pc_i, discard wrong-path state
//   rom_ce_o         : request valid; rom_addr_o is the PC register
//   rom_gnt_i        : memory accepts the request this cycle
//   rom_valid_i      : in-order response word on rom_data_i
//   id_pc_o/id_inst_o: registered pair to decode, NOP = {0, 0}
//   perf_fetch_cnt_o : delivered-instruction count
// Optional feature: define IF_PERF_CNT_EN to build the saturating delivery
// counter; otherwise perf_fetch_cnt_o is tied to ZeroWord.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = IfFifoDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] flush_pc_i,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic                   rom_gnt_i,
  input  logic                   rom_valid_i,
  input  logic [InstBus-1:0]     rom_data_i,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic [31:0]            perf_fetch_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [InstAddrBus-1:0] pc_q;
  logic [InstAddrBus-1:0] resp_pc_q;     // pc of the next accepted response
  logic [CW-1:0]          outstanding_q;
  logic [CW-1:0]          drop_q;        // wrong-path responses still due
  fetch_entry_t           out_q;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic [CW:0]   credit_used;
  logic          grant;
  logic          resp_ok;
  logic          resp_keep;
  logic          deliver;
  logic          pop;
  logic          bypass;
  logic          push;
  fetch_entry_t  resp_entry;
  fetch_entry_t  out_d;

  // Buffered plus in-flight words may never exceed the buffer, so every
  // response always has a slot even while decode is stalled.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign rom_ce_o    = !rst && !flush_i && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign rom_addr_o  = pc_q;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    grant      = rom_ce_o && rom_gnt_i;
    resp_ok    = rom_valid_i && (outstanding_q != '0);  // stray words ignored
    resp_keep  = resp_ok && (drop_q == '0) && !flush_i;
    deliver    = !stall_i && !flush_i;
    pop        = deliver && (fifo_count != '0);
    bypass     = deliver && (fifo_count == '0) && resp_keep;
    push       = resp_keep && !bypass;
    resp_entry = '{pc: resp_pc_q, inst: rom_data_i};
    out_d      = out_q;
    if (flush_i)     out_d = NopEntry;
    else if (pop)    out_d = fifo_head;
    else if (bypass) out_d = resp_entry;
    else if (deliver) out_d = NopEntry;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (push),
    .din   (resp_entry),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      out_q         <= NopEntry;
    end else begin
      outstanding_q <= outstanding_q + CW'(grant) - CW'(resp_ok);
      out_q         <= out_d;
      if (flush_i) begin
        // No grant in a flush cycle, so whatever is still in flight after
        // this cycle's response belongs to the wrong path.
        pc_q      <= flush_pc_i;
        resp_pc_q <= flush_pc_i;
        drop_q    <= outstanding_q - CW'(resp_ok);
      end else begin
        if (grant)     pc_q      <= pc_q + 32'd4;
        if (resp_keep) resp_pc_q <= resp_pc_q + 32'd4;
        if (resp_ok && (drop_q != '0)) drop_q <= drop_q - CW'(1);
      end
    end
  end

  assign id_pc_o   = out_q.pc;
  assign id_inst_o = out_q.inst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_q <= ZeroWord;
    end else if ((pop || bypass) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_q;
`else
  assign perf_fetch_cnt_o = ZeroWord;
`endif

endmodule
